// File: rtl/sine_pos_decoder.sv
// Recovers a 0..15 phase index from an 8-bit offset-binary sine stream, measures
// the period between wraps, and flags backward phase steps.
module sine_pos_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [3:0] pos_out,
  output logic       pos_valid,
  output logic [7:0] period_out,
  output logic       locked,
  output logic       err
);

  localparam int NUM_THR = 8;
  localparam logic [NUM_THR-1:0][7:0] THR = {8'd250, 8'd232, 8'd197, 8'd152,
                                             8'd104, 8'd58,  8'd24,  8'd5};
  localparam logic [3:0] POS_L0  = 4'd12;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // vld_pipe[0]: stage-1 sample, [1]: stage-2 pos, [2]: output strobe
  logic [2:0] vld_pipe;
  logic       accept;

  assign accept    = ena & sample_valid;
  assign pos_valid = vld_pipe[2];

  // ---------------- stage 1: threshold level + direction ----------------
  logic [NUM_THR-1:0] ge;
  logic [3:0]         lvl_in;
  logic [7:0]         s1_sample;
  logic [3:0]         s1_lvl;
  logic               s1_dir;     // 1 = rising
  logic               prev_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THR; gi++) begin : g_thr
      assign ge[gi] = (sample_in >= THR[gi]);
    end
  endgenerate

  always_comb begin
    lvl_in = '0;
    for (int i = 0; i < NUM_THR; i++) lvl_in = lvl_in + {3'd0, ge[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sample <= '0;
      s1_lvl    <= '0;
      s1_dir    <= 1'b1;
      prev_vld  <= 1'b0;
    end else if (accept) begin
      s1_sample <= sample_in;
      s1_lvl    <= lvl_in;
      prev_vld  <= 1'b1;
      // Equal samples keep the previous direction.
      if (!prev_vld || sample_in > s1_sample) s1_dir <= 1'b1;
      else if (sample_in < s1_sample)         s1_dir <= 1'b0;
    end
  end

  // ---------------- stage 2: level -> phase index ----------------
  logic [3:0] s2_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_pos <= '0;
    end else if (ena && vld_pipe[0]) begin
      s2_pos <= s1_dir ? (s1_lvl + POS_L0) : (POS_L0 - s1_lvl);
    end
  end

  // valid shift register; the output strobe drops while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (ena) vld_pipe <= {vld_pipe[1:0], sample_valid};
    else          vld_pipe <= {1'b0, vld_pipe[1:0]};
  end

  // ---------------- output stage: wrap, period, lock, err ----------------
  logic       upd;
  logic [3:0] diff;
  logic       err_now;
  logic       wrap_now;
  logic       have_pos;
  logic       armed;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [7:0] cnt_nx;
  logic [7:0] period_nx;
  logic       locked_nx;
  logic       armed_nx;

  assign upd      = ena & vld_pipe[1];
  assign diff     = s2_pos - pos_out;
  assign err_now  = have_pos & (diff >= 4'd9);
  assign wrap_now = pos_out[3] & ~s2_pos[3];
  assign cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 8'd1;

  always_comb begin
    cnt_nx    = cnt;
    period_nx = period_out;
    locked_nx = locked;
    armed_nx  = armed;
    if (upd) begin
      cnt_nx = wrap_now ? 8'd0 : cnt_inc;
      if (wrap_now) begin
        armed_nx = 1'b1;
        // First wrap only arms; later wraps measure against the last period.
        if (armed) begin
          period_nx = cnt_inc;
          locked_nx = (cnt_inc == period_out) && (cnt_inc != 8'd0) && (cnt_inc != CNT_MAX);
        end
      end
      if (cnt_inc == CNT_MAX) locked_nx = 1'b0;
      if (err_now)            locked_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_out    <= '0;
      err        <= 1'b0;
      have_pos   <= 1'b0;
      armed      <= 1'b0;
      cnt        <= '0;
      period_out <= '0;
      locked     <= 1'b0;
    end else begin
      err        <= upd & err_now;
      cnt        <= cnt_nx;
      period_out <= period_nx;
      locked     <= locked_nx;
      armed      <= armed_nx;
      if (upd) begin
        pos_out  <= s2_pos;
        have_pos <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_pos_decoder.sv
// Directed, table-driven bench for sine_pos_decoder; observations are captured
// on every pos_valid and compared against hand-computed records.
module tb_sine_pos_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [3:0] pos_out;
  logic       pos_valid;
  logic [7:0] period_out;
  logic       locked;
  logic       err;

  sine_pos_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .sample_valid(sample_valid), .pos_out(pos_out), .pos_valid(pos_valid),
    .period_out(period_out), .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] smp;
    logic [3:0] pos;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] pos;
    logic       err;
    logic [7:0] period;
    logic       locked;
  } obs_t;

  vec_t vq[$];
  obs_t obs_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [7:0] per_smp [16];

  always @(negedge clk)
    if (rst_n && pos_valid) obs_q.push_back('{pos_out, err, period_out, locked});

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // Streams vq back to back, then compares each captured pos/err record.
  task automatic run_vecs(input string nm);
    obs_q.delete();
    foreach (vq[i]) send(vq[i].smp);
    idle(4);
    chk($sformatf("%s count", nm), obs_q.size(), vq.size());
    foreach (vq[i]) begin
      if (i < obs_q.size()) begin
        chk($sformatf("%s pos[%0d]", nm, i), obs_q[i].pos, vq[i].pos);
        chk($sformatf("%s err[%0d]", nm, i), obs_q[i].err, vq[i].err);
      end
    end
  endtask

  task automatic chk_obs(input string nm, input int idx, input int per, input int lck);
    if (idx >= obs_q.size()) begin
      chk($sformatf("%s missing obs %0d", nm, idx), 0, 1);
    end else begin
      chk($sformatf("%s period", nm), obs_q[idx].period, per);
      chk($sformatf("%s locked", nm), obs_q[idx].locked, lck);
    end
  endtask

  task automatic push_periods(input int n);
    vq.delete();
    for (int k = 0; k < n; k++) vq.push_back('{per_smp[k % 16], 4'(k % 16), 1'b0});
  endtask

  task automatic vpush(input logic [7:0] s, input logic [3:0] p, input logic e);
    vq.push_back('{s, p, e});
  endtask

  initial begin
    per_smp = '{8'd128, 8'd176, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd176,
                8'd128, 8'd79,  8'd37,  8'd10,  8'd0,   8'd10,  8'd37,  8'd79};
    ena = 1'b1; sample_in = '0; sample_valid = 1'b0; rst_n = 1'b0;

    // reset values
    #3;
    chk("rst pos_out", pos_out, 0);
    chk("rst pos_valid", pos_valid, 0);
    chk("rst period_out", period_out, 0);
    chk("rst locked", locked, 0);
    chk("rst err", err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // single sample latency: strobe exactly two edges after acceptance
    sample_in = 8'd128; sample_valid = 1'b1;
    @(posedge clk); #1; sample_valid = 1'b0;
    @(negedge clk); chk("lat edge+0 pos_valid", pos_valid, 0);
    @(negedge clk); chk("lat edge+1 pos_valid", pos_valid, 0);
    @(negedge clk);
    chk("lat edge+2 pos_valid", pos_valid, 1);
    chk("lat edge+2 pos_out", pos_out, 0);
    chk("lat edge+2 err", err, 0);
    @(negedge clk); chk("lat strobe one cycle", pos_valid, 0);
    idle(1);

    // falling map and a 7 -> 1 backward step
    vq.delete();
    vpush(8'd176, 4'd1, 1'b0);
    vpush(8'd218, 4'd2, 1'b0);
    vpush(8'd176, 4'd7, 1'b0);
    vpush(8'd177, 4'd1, 1'b1);
    run_vecs("dir");

    // three periods plus wrap sample: arm, measure 16, lock
    do_reset();
    push_periods(49);
    run_vecs("per16");
    chk_obs("wrap1", 16, 0, 0);
    chk_obs("wrap2", 32, 16, 0);
    chk_obs("wrap3", 48, 16, 1);

    // 20-sample period after lock
    vq.delete();
    vpush(8'd176, 4'd1, 1'b0); vpush(8'd218, 4'd2, 1'b0); vpush(8'd245, 4'd3, 1'b0);
    for (int k = 0; k < 5; k++) vpush(8'd255, 4'd4, 1'b0);
    vpush(8'd245, 4'd5, 1'b0); vpush(8'd218, 4'd6, 1'b0); vpush(8'd176, 4'd7, 1'b0);
    vpush(8'd128, 4'd8, 1'b0); vpush(8'd79, 4'd9, 1'b0);  vpush(8'd37, 4'd10, 1'b0);
    vpush(8'd10, 4'd11, 1'b0); vpush(8'd0, 4'd12, 1'b0);  vpush(8'd10, 4'd13, 1'b0);
    vpush(8'd37, 4'd14, 1'b0); vpush(8'd79, 4'd15, 1'b0); vpush(8'd128, 4'd0, 1'b0);
    run_vecs("per20");
    chk_obs("per20 start", 0, 16, 1);
    chk_obs("per20 wrap", 19, 20, 0);

    // backward step 5 -> 3 while locked
    do_reset();
    push_periods(49);
    run_vecs("relock");
    vq.delete();
    vpush(8'd176, 4'd1, 1'b0); vpush(8'd218, 4'd2, 1'b0); vpush(8'd245, 4'd3, 1'b0);
    vpush(8'd255, 4'd4, 1'b0); vpush(8'd245, 4'd5, 1'b0); vpush(8'd246, 4'd3, 1'b1);
    vpush(8'd247, 4'd3, 1'b0);
    run_vecs("err");
    chk_obs("err before", 4, 16, 1);
    chk_obs("err clears lock", 5, 16, 0);

    // counter saturation clears lock
    do_reset();
    push_periods(49);
    run_vecs("presat");
    vq.delete();
    for (int k = 0; k < 256; k++) vpush(8'd255, 4'd4, 1'b0);
    run_vecs("sat");
    chk_obs("sat cnt254", 253, 16, 1);
    chk_obs("sat cnt255", 254, 16, 0);

    // ena low freezes the pipeline
    do_reset();
    obs_q.delete();
    send(8'd128); send(8'd176); send(8'd218); send(8'd245);
    ena = 1'b0; sample_in = 8'd10; sample_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("ena0 pos_valid[%0d]", k), pos_valid, 0);
      chk($sformatf("ena0 pos_out[%0d]", k), pos_out, 1);
    end
    ena = 1'b1; sample_valid = 1'b0;
    idle(4);
    chk("ena resume count", obs_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < obs_q.size()) chk($sformatf("ena resume pos[%0d]", k), obs_q[k].pos, k);

    // reset mid-stream discards in-flight samples
    obs_q.delete();
    send(8'd255); send(8'd245);
    rst_n = 1'b0;
    #1;
    chk("midrst pos_out", pos_out, 0);
    chk("midrst pos_valid", pos_valid, 0);
    chk("midrst period_out", period_out, 0);
    chk("midrst locked", locked, 0);
    chk("midrst err", err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("midrst discarded", obs_q.size(), 0);
    vq.delete();
    vpush(8'd218, 4'd2, 1'b0);
    run_vecs("first after rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
